// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host scan code receiver.
// Synchronises and deglitches the raw PS/2 pins, deframes 11-bit frames and
// folds E0/F0/E1 prefix bytes into single key events on the ps2_key bus.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err,
  output logic        busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_meta, clk_sync, data_meta, data_sync;
  logic          clk_filt, data_filt, clk_filt_prev;
  logic [FW-1:0] clk_cnt, data_cnt;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic [TW-1:0] tcnt;
  logic          ext, brk;
  logic [2:0]    skip_cnt;

  // Two-stage synchronisers on both pins; idle bus level is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Clock line filter: flip only after FILTER_LEN consecutive opposite samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      clk_cnt  <= '0;
    end else if (clk_sync == clk_filt) begin
      clk_cnt <= '0;
    end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_sync;
      clk_cnt  <= '0;
    end else begin
      clk_cnt <= clk_cnt + FW'(1);
    end
  end

  // Data line filter, identical behaviour to the clock line filter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_filt <= 1'b1;
      data_cnt  <= '0;
    end else if (data_sync == data_filt) begin
      data_cnt <= '0;
    end else if (data_cnt == FW'(FILTER_LEN - 1)) begin
      data_filt <= data_sync;
      data_cnt  <= '0;
    end else begin
      data_cnt <= data_cnt + FW'(1);
    end
  end

  // Delayed filtered clock for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clk_filt_prev <= 1'b1;
    else          clk_filt_prev <= clk_filt;
  end

  assign fall = clk_filt_prev & ~clk_filt;
  assign busy = (state != IDLE);

  // Frame deframer, timeout watchdog and prefix folding into key events
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tcnt       <= '0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      skip_cnt   <= '0;
      ps2_key    <= '0;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!data_filt) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {data_filt, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_filt;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!data_filt || !(^{shift, parity_bit})) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
              skip_cnt  <= '0;
            end else if (skip_cnt != 3'd0) begin
              skip_cnt <= skip_cnt - 3'd1;
            end else if (shift == 8'hE1) begin
              skip_cnt <= 3'd7;
            end else if (shift == 8'h00 || shift == 8'hFF) begin
              ext <= 1'b0;
              brk <= 1'b0;
            end else if (!ext && !brk &&
                         (shift == 8'hAA || shift == 8'hFA ||
                          shift == 8'hEE || shift == 8'hFE)) begin
              ext <= ext;
            end else if (shift == 8'hE0) begin
              ext <= 1'b1;
            end else if (shift == 8'hF0) begin
              brk <= 1'b1;
            end else begin
              ps2_key    <= {~ps2_key[10], ~brk, ext, shift};
              key_strobe <= 1'b1;
              ext        <= 1'b0;
              brk        <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
        tcnt      <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule
